// File: rtl/sbox_pow5_sequencer_pkg.sv
// Shared definitions for the x^5 S-box sequencer: state encoding, default width
// and the BLS12-381 scalar-field Montgomery constants (R = 2^255).
package sbox_pow5_sequencer_pkg;

    localparam int DATA_WIDTH_DEFAULT = 255;

    localparam logic [255:0] MODULUS_256 =
        256'h73eda753299d7d483339d80809a1d80553bda402fffe5bfeffffffff00000001;
    localparam logic [255:0] MONT_ONE_256 =
        256'h0c1258acd66282b7ccc627f7f65e27faac425bfd0001a40100000000ffffffff;

    localparam logic [DATA_WIDTH_DEFAULT-1:0] MODULUS  = MODULUS_256[DATA_WIDTH_DEFAULT-1:0];
    // Montgomery form of 1, i.e. R mod MODULUS.
    localparam logic [DATA_WIDTH_DEFAULT-1:0] MONT_ONE = MONT_ONE_256[DATA_WIDTH_DEFAULT-1:0];
    localparam logic [DATA_WIDTH_DEFAULT-1:0] MOD_COMPENSATION = MONT_ONE;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SQ1_REQ  = 3'd1,
        ST_SQ1_WAIT = 3'd2,
        ST_SQ2_REQ  = 3'd3,
        ST_SQ2_WAIT = 3'd4,
        ST_MUL_REQ  = 3'd5,
        ST_MUL_WAIT = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    function automatic logic is_req(input state_e s);
        return s inside {ST_SQ1_REQ, ST_SQ2_REQ, ST_MUL_REQ};
    endfunction

    function automatic logic is_wait(input state_e s);
        return s inside {ST_SQ1_WAIT, ST_SQ2_WAIT, ST_MUL_WAIT};
    endfunction

endpackage

// File: rtl/sbox_pow5_sequencer.sv
// Drives one Montgomery multiplier through x2=x*x, x4=x2*x2, x5=x4*x.
// Optional SBOX_ZERO_SKIP_EN: a zero input bypasses the multiplier entirely.
module sbox_pow5_sequencer
    import sbox_pow5_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  mul_valid_o,
    input  logic                  mul_ready_i,
    output logic [DATA_WIDTH-1:0] mul_op1_o,
    output logic [DATA_WIDTH-1:0] mul_op2_o,
    input  logic                  mul_res_valid_i,
    output logic                  mul_res_ready_o,
    input  logic [DATA_WIDTH-1:0] mul_res_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] x_reg_q, x_reg_d;
    logic [DATA_WIDTH-1:0] acc_reg_q, acc_reg_d;

    logic                  in_ready_q, in_ready_d;
    logic                  mul_valid_q, mul_valid_d;
    logic                  mul_res_ready_q, mul_res_ready_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [DATA_WIDTH-1:0] mul_op1_q, mul_op1_d;
    logic [DATA_WIDTH-1:0] mul_op2_q, mul_op2_d;

    logic in_hs, mul_hs, res_hs, out_hs;

    assign in_hs  = in_valid_i      & in_ready_q;
    assign mul_hs = mul_valid_q     & mul_ready_i;
    assign res_hs = mul_res_valid_i & mul_res_ready_q;
    assign out_hs = out_valid_q     & out_ready_i;

    always_comb begin
        // NOTE: every _d is defaulted first so no branch leaves it unassigned (no latches).
        state_d   = state_q;
        x_reg_d   = x_reg_q;
        acc_reg_d = acc_reg_q;

        unique case (state_q)
            ST_IDLE: begin
                if (in_hs) begin
                    x_reg_d = in_data_i;
                    state_d = ST_SQ1_REQ;
`ifdef SBOX_ZERO_SKIP_EN
                    if (in_data_i == '0) begin
                        acc_reg_d = '0;
                        state_d   = ST_DONE;
                    end
`endif
                end
            end
            ST_SQ1_REQ:  if (mul_hs) state_d = ST_SQ1_WAIT;
            ST_SQ2_REQ:  if (mul_hs) state_d = ST_SQ2_WAIT;
            ST_MUL_REQ:  if (mul_hs) state_d = ST_MUL_WAIT;
            ST_SQ1_WAIT: if (res_hs) begin acc_reg_d = mul_res_i; state_d = ST_SQ2_REQ; end
            ST_SQ2_WAIT: if (res_hs) begin acc_reg_d = mul_res_i; state_d = ST_MUL_REQ; end
            ST_MUL_WAIT: if (res_hs) begin acc_reg_d = mul_res_i; state_d = ST_DONE;    end
            ST_DONE:     if (out_hs) state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase

        // Outputs are decoded from the next state and registered, so a stalled
        // request keeps valid and operands frozen and mul_res_i never reaches the operands.
        in_ready_d      = (state_d == ST_IDLE);
        mul_valid_d     = is_req(state_d);
        mul_res_ready_d = is_wait(state_d);
        out_valid_d     = (state_d == ST_DONE);
        out_data_d      = out_valid_d ? acc_reg_d : '0;

        mul_op1_d = '0;
        mul_op2_d = '0;
        unique case (state_d)
            ST_SQ1_REQ: begin mul_op1_d = x_reg_d;   mul_op2_d = x_reg_d;   end
            ST_SQ2_REQ: begin mul_op1_d = acc_reg_d; mul_op2_d = acc_reg_d; end
            ST_MUL_REQ: begin mul_op1_d = acc_reg_d; mul_op2_d = x_reg_d;   end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples values from before the edge.
        if (rst) begin
            state_q         <= ST_IDLE;
            x_reg_q         <= '0;
            acc_reg_q       <= '0;
            in_ready_q      <= 1'b1;
            mul_valid_q     <= 1'b0;
            mul_res_ready_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            mul_op1_q       <= '0;
            mul_op2_q       <= '0;
        end else begin
            state_q         <= state_d;
            x_reg_q         <= x_reg_d;
            acc_reg_q       <= acc_reg_d;
            in_ready_q      <= in_ready_d;
            mul_valid_q     <= mul_valid_d;
            mul_res_ready_q <= mul_res_ready_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            mul_op1_q       <= mul_op1_d;
            mul_op2_q       <= mul_op2_d;
        end
    end

    assign in_ready_o      = in_ready_q;
    assign mul_valid_o     = mul_valid_q;
    assign mul_res_ready_o = mul_res_ready_q;
    assign out_valid_o     = out_valid_q;
    assign out_data_o      = out_data_q;
    assign mul_op1_o       = mul_op1_q;
    assign mul_op2_o       = mul_op2_q;

endmodule

// File: tb/tb_sbox_pow5_sequencer.sv
// Bench for sbox_pow5_sequencer: behavioural Montgomery multiplier (3-cycle latency)
// plus a value-domain reference of x^5; honours SBOX_ZERO_SKIP_EN.
module tb_sbox_pow5_sequencer;
    import sbox_pow5_sequencer_pkg::*;

    localparam int DW = DATA_WIDTH_DEFAULT;
    typedef logic [DW-1:0]   fe_t;
    typedef logic [2*DW-1:0] wide_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready;
    fe_t  in_data = '0;
    logic mul_valid, mul_ready, mul_res_valid, mul_res_ready;
    fe_t  mul_op1, mul_op2, mul_res;
    logic out_valid, out_ready = 1'b0;
    fe_t  out_data;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    sbox_pow5_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data),
        .mul_valid_o(mul_valid), .mul_ready_i(mul_ready),
        .mul_op1_o(mul_op1), .mul_op2_o(mul_op2),
        .mul_res_valid_i(mul_res_valid), .mul_res_ready_o(mul_res_ready), .mul_res_i(mul_res),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data)
    );

    // ---------------- field arithmetic in the plain value domain ----------------
    function automatic fe_t mulmod(input fe_t a, input fe_t b);
        logic [2*DW+1:0] t;
        t = {{(DW+2){1'b0}}, a} * {{(DW+2){1'b0}}, b};
        t = t % {{(DW+2){1'b0}}, MODULUS};
        return t[DW-1:0];
    endfunction

    function automatic fe_t to_mont(input fe_t v);
        logic [2*DW+1:0] t;
        t = {2'b00, v, {DW{1'b0}}};
        t = t % {{(DW+2){1'b0}}, MODULUS};
        return t[DW-1:0];
    endfunction

    // Bit-serial REDC: a*b*2^-DW mod MODULUS, as the attached multiplier returns.
    function automatic fe_t mont_redc(input fe_t a, input fe_t b);
        logic [DW+1:0] t;
        t = '0;
        for (int i = 0; i < DW; i++) begin
            if (a[i]) t = t + {2'b00, b};
            if (t[0]) t = t + {2'b00, MODULUS};
            t = t >> 1;
        end
        if (t >= {2'b00, MODULUS}) t = t - {2'b00, MODULUS};
        return t[DW-1:0];
    endfunction

    function automatic fe_t rand_val();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        r = r % {1'b0, MODULUS};
        return r[DW-1:0];
    endfunction

    // ---------------- multiplier model ----------------
    logic  m_pending = 1'b0, m_res_valid = 1'b0;
    int    m_cnt = 0;
    fe_t   m_res = '0;
    int    req_count = 0;
    wide_t op_log[$];
    logic  stall_en = 1'b0, spur_res = 1'b0;

    assign mul_ready     = !m_pending && !stall_en;
    assign mul_res_valid = m_res_valid || spur_res;
    assign mul_res       = spur_res ? '1 : m_res;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst) begin
            m_pending   <= 1'b0;
            m_res_valid <= 1'b0;
            m_cnt       <= 0;
        end else begin
            if (mul_valid && mul_ready) begin
                m_pending <= 1'b1;
                m_cnt     <= 2;
                m_res     <= mont_redc(mul_op1, mul_op2);
                req_count <= req_count + 1;
                op_log.push_back({mul_op1, mul_op2});
            end else if (m_pending && !m_res_valid) begin
                if (m_cnt == 1) m_res_valid <= 1'b1;
                m_cnt <= m_cnt - 1;
            end
            if (m_res_valid && mul_res_ready) begin
                m_res_valid <= 1'b0;
                m_pending   <= 1'b0;
            end
        end
    end

    // ---------------- checking ----------------
    task automatic check_wide(input string tag, input wide_t obs, input wide_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_fe(input string tag, input fe_t obs, input fe_t exp);
        check_wide(tag, {{DW{1'b0}}, obs}, {{DW{1'b0}}, exp});
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        check_wide(tag, {{(2*DW-32){1'b0}}, obs}, {{(2*DW-32){1'b0}}, exp});
    endtask

    // One element end to end; latency = edges from input handshake to output handshake.
    task automatic run_elem(input fe_t v, input string tag, input int out_hold,
                            input bit do_stall, input bit do_spur);
        fe_t   xm, x2m, x4m, x5m, snap;
        int    base, n0, lat, nreq, rq;
        bit    to, stable, skip;
        wide_t exp_ops[3];

        xm  = to_mont(v);
        x2m = to_mont(mulmod(v, v));
        x4m = to_mont(mulmod(mulmod(v, v), mulmod(v, v)));
        x5m = to_mont(mulmod(mulmod(mulmod(v, v), mulmod(v, v)), v));
        exp_ops[0] = {xm, xm};
        exp_ops[1] = {x2m, x2m};
        exp_ops[2] = {x4m, xm};
`ifdef SBOX_ZERO_SKIP_EN
        skip = (v == '0);
`else
        skip = 1'b0;
`endif
        nreq = skip ? 0 : 3;
        base = req_count;

        @(negedge clk);
        for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
        check_int({tag, " in_ready"}, int'(in_ready), 1);
        in_valid = 1'b1;
        in_data  = xm;
        @(posedge clk);
        #1;
        n0 = cyc;
        in_valid = 1'b0;

        if (do_stall) begin
            to = 1'b1;
            for (int i = 0; i < 100; i++) begin
                @(negedge clk);
                if (req_count == base + 1) begin to = 1'b0; break; end
            end
            stall_en = 1'b1;
            for (int i = 0; i < 50 && !mul_valid; i++) @(negedge clk);
            stable = !to;
            for (int k = 0; k < 5; k++) begin
                if (!(mul_valid && mul_op1 == x2m && mul_op2 == x2m && req_count == base + 1))
                    stable = 1'b0;
                @(negedge clk);
            end
            stall_en = 1'b0;
            check_int({tag, " sq2 stall hold"}, int'(stable), 1);
        end

        to = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (out_valid) begin to = 1'b0; break; end
            @(negedge clk);
        end
        check_int({tag, " out timeout"}, int'(to), 0);
        lat = cyc - n0 + 1;
        if (out_hold == 0 && !do_stall)
            check_int({tag, " latency"}, lat, skip ? 1 : 13);
        check_fe({tag, " out_data"}, out_data, x5m);

        if (out_hold > 0) begin
            snap   = out_data;
            rq     = req_count;
            stable = 1'b1;
            spur_res = do_spur;
            for (int k = 0; k < out_hold; k++) begin
                @(negedge clk);
                if (!(out_valid && out_data == snap && !in_ready && req_count == rq
                      && !mul_valid && !mul_res_ready))
                    stable = 1'b0;
            end
            spur_res = 1'b0;
            check_int({tag, " done hold"}, int'(stable), 1);
            check_fe({tag, " out_data after hold"}, out_data, x5m);
        end

        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_int({tag, " idle after out"}, int'({out_valid, in_ready}), 1);
        check_int({tag, " mul requests"}, req_count - base, nreq);
        for (int k = 0; k < nreq; k++)
            check_wide($sformatf("%s ops%0d", tag, k),
                       (op_log.size() > base + k) ? op_log[base + k] : '1, exp_ops[k]);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  base;
        bit  to;

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_int("reset in_ready", int'(in_ready), 1);
        check_int("reset mul_valid", int'(mul_valid), 0);
        check_int("reset mul_res_ready", int'(mul_res_ready), 0);
        check_int("reset out_valid", int'(out_valid), 0);
        check_fe("reset out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;

        run_elem(fe_t'(1), "one",   0, 1'b0, 1'b0);
        run_elem(fe_t'(2), "two",   0, 1'b0, 1'b0);
        run_elem(fe_t'(3), "three", 0, 1'b0, 1'b0);
        run_elem(rand_val(), "rand_hold",  20, 1'b0, 1'b1);
        run_elem(rand_val(), "rand_stall",  0, 1'b1, 1'b0);

        // Reset while the second square is outstanding.
        base = req_count;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = to_mont(fe_t'(5));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (req_count == base + 2) begin to = 1'b0; break; end
        end
        check_int("mid rst reach sq2_wait", int'(to), 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_int("mid rst flags", int'({in_ready, mul_valid, mul_res_ready, out_valid}), 8);
        check_fe("mid rst out_data", out_data, '0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_int("mid rst no new req", req_count - base, 2);

        run_elem(fe_t'(2), "two_after_rst", 0, 1'b0, 1'b0);
        run_elem(fe_t'(0), "zero", 0, 1'b0, 1'b0);
        run_elem(rand_val(), "rand_a", 0, 1'b0, 1'b0);
        run_elem(rand_val(), "rand_b", 3, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sbox_pow5_sequencer.md
Name: sbox_pow5_sequencer

Overview:
- Initiator-side controller that drives the existing Montgomery modular multiplier over its op/res valid-ready interface.
- Computes the Poseidon S-box x^5 mod MODULUS as three chained Montgomery multiplications: x2=x*x, x4=x2*x2, x5=x4*x.
- Input and output are both in Montgomery form; the form is preserved because each Montgomery product stays in-domain.
- Sits between round-constant addition and the MDS stage; one instance per multiplier.

Parameters:
DATA_WIDTH, 255, field element width; must match the attached multiplier.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-high reset
in_valid_i  in  1  upstream element valid
in_ready_o  out  1  sequencer can accept an element
in_data_i  in  DATA_WIDTH  x, Montgomery form
mul_valid_o  out  1  request to multiplier (to its op_valid_i)
mul_ready_i  in  1  multiplier accepts request (its op_ready_o)
mul_op1_o  out  DATA_WIDTH  operand 1
mul_op2_o  out  DATA_WIDTH  operand 2
mul_res_valid_i  in  1  multiplier result valid (its res_valid_o)
mul_res_ready_o  out  1  sequencer accepts result (to its res_ready_i)
mul_res_i  in  DATA_WIDTH  multiplier product
out_valid_o  out  1  x^5 valid
out_ready_i  in  1  downstream accepts
out_data_o  out  DATA_WIDTH  x^5, Montgomery form

Behaviour:
- Reset values (clk edge with rst=1): state=IDLE; x_reg=0; acc_reg=0; in_ready_o=1; mul_valid_o=0; mul_res_ready_o=0; out_valid_o=0; out_data_o=0.
- rst mid-operation returns to IDLE and discards work. The multiplier shares the same rst, so no stale response survives.
- States and transitions:
  - IDLE: in_ready_o=1. On in handshake: x_reg<=in_data_i, go SQ1_REQ.
  - SQ1_REQ: mul_valid_o=1, ops=(x_reg,x_reg). On mul handshake go SQ1_WAIT.
  - SQ1_WAIT: mul_res_ready_o=1. On res handshake: acc_reg<=mul_res_i, go SQ2_REQ.
  - SQ2_REQ: ops=(acc_reg,acc_reg) → SQ2_WAIT.
  - SQ2_WAIT: capture acc_reg → MUL_REQ.
  - MUL_REQ: ops=(acc_reg,x_reg) → MUL_WAIT.
  - MUL_WAIT: capture acc_reg → DONE.
  - DONE: out_valid_o=1, out_data_o=acc_reg. On out handshake go IDLE.
- Request rules:
  - mul_valid_o and operands are registered/state-decoded only; no combinational path from mul_res_i to mul_op*_o.
  - Once asserted, mul_valid_o and operands hold stable until mul_ready_i.
- Response rules:
  - mul_res_ready_o is high only in *_WAIT states.
  - A mul_res_valid_i outside the WAIT states is a protocol error; the sequencer ignores it and does not accept it.
- Throughput:
  - in_ready_o is 0 outside IDLE; no overlap between elements.
  - With the multiplier's 3-cycle issue-to-result latency and no backpressure: input handshake to out_valid_o = 13 cycles; next input accepted the cycle after the out handshake.
- Stall handling: out_ready_i=0 in DONE holds out_data_o stable indefinitely. mul_ready_i=0 stalls the REQ state with no state change.
- Arithmetic: no reduction is done here; results are exactly as the multiplier returns them.

Optional Feature:
- Macro: SBOX_ZERO_SKIP_EN.
- Defined:
  - In IDLE, an input handshake with in_data_i==0 goes directly to DONE with acc_reg<=0.
  - No multiplier requests are issued.
  - Latency is 1 cycle.
- Undefined: zero takes the normal 3-multiply path and returns 0.

Decomposition:
- Shared package holds:
  - the state enum encoding (3-bit, IDLE=0 … DONE=7)
  - DATA_WIDTH default
  - MONT_ONE = R mod MODULUS = MOD_COMPENSATION, for benches.
- No sub-module; one FSM plus two data registers. Top-level integration wires this block to one multiplier instance.

Test Plan:
- in=MONT_ONE (0x0c1258acd…ffffffff), ready always high → exactly 3 mul handshakes with ops (1,1),(1,1),(1,1) in Montgomery form; out=MONT_ONE after 13 cycles.
- in=Montgomery(2) → out=Montgomery(32), checked against a software model.
- Operand-order check: in=Montgomery(3) → mul ops observed (x,x),(x2,x2),(x4,x); out=Montgomery(243).
- out_ready_i=0 for 20 cycles in DONE → out_valid_o and out_data_o stable; in_ready_o=0; no mul requests.
- mul_ready_i low 5 cycles in SQ2_REQ → mul_valid_o and operands held; final result unchanged.
- rst asserted in SQ2_WAIT, then in=Montgomery(2) → out=Montgomery(32). Then in=0 with SBOX_ZERO_SKIP_EN defined → out=0 next cycle with zero mul requests; without the macro, 3 requests and out=0.
